// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over a req/ack port into
// a small queue and presents them to decode over valid/ready; handles redirects and HALT.
module instr_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'b1111
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [15:0] ImemData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [15:0] Instr,
  output logic [3:0]  Opcode,
  output logic [15:0] InstrPC,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  output logic        Halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HALT} fetchState_t;

  fetchState_t      state, nextState;
  logic [15:0]      pc, pcNext;
  logic [15:0]      qInstr [DEPTH];
  logic [15:0]      qPC    [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             notEmpty, push, pop;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign notEmpty = (count != '0);
  // A redirect kills both the ack in flight and any pop this cycle.
  assign push     = (state == S_WAIT) && ImemAck && !BranchTaken;
  assign pop      = notEmpty && InstrReady && !BranchTaken;

  // NOTE: always_comb gives every output a default first so no path leaves a latch.
  always_comb begin
    nextState = state;
    pcNext    = pc;
    unique case (state)
      S_IDLE: begin
        if (!BranchTaken && (count < CNT_FULL)) nextState = S_WAIT;
      end
      S_WAIT: begin
        if (ImemAck) begin
          nextState = (push && (ImemData[15:12] == HALT_OP)) ? S_HALT : S_IDLE;
        end else if (BranchTaken) begin
          nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ImemAck) nextState = S_IDLE;
      end
      S_HALT: begin
        if (BranchTaken) nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
    if (BranchTaken) pcNext = {BranchTarget[15:1], 1'b0};
    else if (push)   pcNext = pc + 16'd2;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= nextState;
      pc    <= pcNext;
      if (BranchTaken) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= ptrInc(tail);
        if (pop)  head <= ptrInc(head);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: queue storage has no reset; the outputs are gated by notEmpty, so stale contents never escape.
  always_ff @(posedge Clock) begin
    if (push) begin
      qInstr[tail] <= ImemData;
      qPC[tail]    <= pc;
    end
  end

  assign ImemReq    = (state == S_WAIT);
  assign ImemAddr   = pc;
  assign InstrValid = notEmpty;
  assign Instr      = notEmpty ? qInstr[head] : '0;
  assign InstrPC    = notEmpty ? qPC[head] : '0;
  assign Opcode     = Instr[15:12];
  assign Halted     = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-by-cycle vector table for the default
// instance plus a hand-written sequence for a RESET_PC=16'hFFFE instance.
module tb_instr_fetch_unit;

  typedef struct {
    logic        ack;
    logic [15:0] data;
    logic        ready;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [15:0] pc;
    logic        halted;
  } vec_t;

  logic        Clock;
  logic        Reset;
  logic        ImemReq, ImemAck, InstrValid, InstrReady, BranchTaken, Halted;
  logic [15:0] ImemAddr, ImemData, Instr, InstrPC, BranchTarget;
  logic [3:0]  Opcode;

  logic        hReset;
  logic        hImemReq, hImemAck, hInstrValid, hInstrReady, hBranchTaken, hHalted;
  logic [15:0] hImemAddr, hImemData, hInstr, hInstrPC, hBranchTarget;
  logic [3:0]  hOpcode;

  int   testsRun  = 0;
  int   failCount = 0;
  vec_t vecs[$];

  instr_fetch_unit dut (
    .Clock(Clock), .Reset(Reset),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .Opcode(Opcode),
    .InstrPC(InstrPC), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Halted(Halted)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dutHi (
    .Clock(Clock), .Reset(hReset),
    .ImemReq(hImemReq), .ImemAddr(hImemAddr), .ImemAck(hImemAck), .ImemData(hImemData),
    .InstrValid(hInstrValid), .InstrReady(hInstrReady), .Instr(hInstr), .Opcode(hOpcode),
    .InstrPC(hInstrPC), .BranchTaken(hBranchTaken), .BranchTarget(hBranchTarget),
    .Halted(hHalted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic ack, input logic [15:0] data, input logic ready,
                        input logic br, input logic [15:0] tgt,
                        input logic req, input logic [15:0] addr, input logic valid,
                        input logic [15:0] instr, input logic [3:0] op,
                        input logic [15:0] pc, input logic halted);
    vec_t v;
    v.ack = ack; v.data = data; v.ready = ready; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.op = op;
    v.pc = pc; v.halted = halted;
    vecs.push_back(v);
  endtask

  task automatic checkMain(input string tag, input logic req, input logic [15:0] addr,
                           input logic valid, input logic [15:0] instr, input logic [3:0] op,
                           input logic [15:0] pc, input logic halted);
    check({tag, " req"},    {15'd0, ImemReq},    {15'd0, req});
    check({tag, " addr"},   ImemAddr,            addr);
    check({tag, " valid"},  {15'd0, InstrValid}, {15'd0, valid});
    check({tag, " instr"},  Instr,               instr);
    check({tag, " opcode"}, {12'd0, Opcode},     {12'd0, op});
    check({tag, " instrpc"},InstrPC,             pc);
    check({tag, " halted"}, {15'd0, Halted},     {15'd0, halted});
  endtask

  task automatic checkHi(input string tag, input logic req, input logic [15:0] addr,
                         input logic valid, input logic [15:0] instr, input logic [3:0] op,
                         input logic [15:0] pc, input logic halted);
    check({tag, " req"},    {15'd0, hImemReq},    {15'd0, req});
    check({tag, " addr"},   hImemAddr,            addr);
    check({tag, " valid"},  {15'd0, hInstrValid}, {15'd0, valid});
    check({tag, " instr"},  hInstr,               instr);
    check({tag, " opcode"}, {12'd0, hOpcode},     {12'd0, op});
    check({tag, " instrpc"},hInstrPC,             pc);
    check({tag, " halted"}, {15'd0, hHalted},     {15'd0, halted});
  endtask

  initial begin
    // Each row: inputs for the coming edge | outputs expected before that edge.
    // Zero-wait memory: ack is driven in the first cycle ImemReq is seen high.
    addVec(1'b1, 16'h0123, 1'b1, 1'b0, 16'h0000,  1'b1, 16'h0000, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0002, 1'b1, 16'h0123, 4'h0, 16'h0000, 1'b0);
    addVec(1'b1, 16'h1456, 1'b1, 1'b0, 16'h0000,  1'b1, 16'h0002, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0004, 1'b1, 16'h1456, 4'h1, 16'h0002, 1'b0);
    addVec(1'b1, 16'h9ABC, 1'b1, 1'b0, 16'h0000,  1'b1, 16'h0004, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0006, 1'b1, 16'h9ABC, 4'h9, 16'h0004, 1'b0);
    // Redirect to 0x0041 while the fetch to 0x0006 waits; stale ack arrives 3 cycles late.
    addVec(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0041,  1'b1, 16'h0006, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0040, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0040, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0040, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0040, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    // Redirect to 0x0100 coinciding with the ack: data dropped, PC not advanced.
    addVec(1'b1, 16'h2040, 1'b1, 1'b1, 16'h0100,  1'b1, 16'h0040, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  1'b0, 16'h0100, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    // Decode stalled: queue fills to DEPTH, requests stop, head held.
    addVec(1'b1, 16'h3100, 1'b0, 1'b0, 16'h0000,  1'b1, 16'h0100, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  1'b0, 16'h0102, 1'b1, 16'h3100, 4'h3, 16'h0100, 1'b0);
    addVec(1'b1, 16'h4102, 1'b0, 1'b0, 16'h0000,  1'b1, 16'h0102, 1'b1, 16'h3100, 4'h3, 16'h0100, 1'b0);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  1'b0, 16'h0104, 1'b1, 16'h3100, 4'h3, 16'h0100, 1'b0);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  1'b0, 16'h0104, 1'b1, 16'h3100, 4'h3, 16'h0100, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0104, 1'b1, 16'h3100, 4'h3, 16'h0100, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0104, 1'b1, 16'h4102, 4'h4, 16'h0102, 1'b0);
    addVec(1'b1, 16'h5104, 1'b1, 1'b0, 16'h0000,  1'b1, 16'h0104, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    // Flush beats a simultaneous pop; redirect to 0x0008 where HALT lives.
    addVec(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008,  1'b0, 16'h0106, 1'b1, 16'h5104, 4'h5, 16'h0104, 1'b0);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  1'b0, 16'h0008, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000,  1'b1, 16'h0008, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000,  1'b0, 16'h000A, 1'b1, 16'hF000, 4'hF, 16'h0008, 1'b1);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h000A, 1'b1, 16'hF000, 4'hF, 16'h0008, 1'b1);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h000A, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b1);
    addVec(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000,  1'b0, 16'h000A, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b1);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b1, 16'h0777, 1'b1, 1'b0, 16'h0000,  1'b1, 16'h0000, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b0, 16'h0002, 1'b1, 16'h0777, 4'h0, 16'h0000, 1'b0);
    addVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000,  1'b1, 16'h0002, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);

    Reset = 1'b1;  ImemAck = 1'b0;  ImemData = '0;  InstrReady = 1'b1;
    BranchTaken = 1'b0;  BranchTarget = '0;
    hReset = 1'b1; hImemAck = 1'b0; hImemData = '0; hInstrReady = 1'b0;
    hBranchTaken = 1'b0; hBranchTarget = '0;

    repeat (2) @(negedge Clock);
    checkMain("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      checkMain($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                vecs[i].instr, vecs[i].op, vecs[i].pc, vecs[i].halted);
      ImemAck      = vecs[i].ack;
      ImemData     = vecs[i].data;
      InstrReady   = vecs[i].ready;
      BranchTaken  = vecs[i].br;
      BranchTarget = vecs[i].tgt;
    end
    @(negedge Clock);
    ImemAck = 1'b0; BranchTaken = 1'b0;

    // RESET_PC = 0xFFFE: PC wraps to 0x0000; async reset mid-WAIT; stale ack ignored.
    checkHi("hi reset", 1'b0, 16'hFFFE, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    hReset = 1'b0;
    @(negedge Clock);
    checkHi("hi fetch1", 1'b1, 16'hFFFE, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    hImemAck = 1'b1; hImemData = 16'h1111;
    @(negedge Clock);
    hImemAck = 1'b0;
    checkHi("hi wrap", 1'b0, 16'h0000, 1'b1, 16'h1111, 4'h1, 16'hFFFE, 1'b0);
    @(negedge Clock);
    checkHi("hi fetch2", 1'b1, 16'h0000, 1'b1, 16'h1111, 4'h1, 16'hFFFE, 1'b0);
    #2 hReset = 1'b1;
    #1 checkHi("hi async reset", 1'b0, 16'hFFFE, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    @(negedge Clock);
    hReset = 1'b0; hImemAck = 1'b1; hImemData = 16'hF222;
    @(negedge Clock);
    hImemAck = 1'b0;
    checkHi("hi stale ignored", 1'b1, 16'hFFFE, 1'b0, 16'h0000, 4'h0, 16'h0000, 1'b0);
    hImemAck = 1'b1; hImemData = 16'h2222;
    @(negedge Clock);
    hImemAck = 1'b0;
    checkHi("hi refetch", 1'b0, 16'h0000, 1'b1, 16'h2222, 4'h2, 16'hFFFE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
